scoreboard_regfile: RTL

//  Multi-ported architectural register file with a per-register producer

---
 rtl/scoreboard_regfile_pkg.sv | 10 +
 rtl/scoreboard_regfile_if.sv | 39 +++
 rtl/scoreboard_regfile_chk.sv | 30 +++
 rtl/scoreboard_regfile_rport.sv | 55 +++++
 rtl/scoreboard_regfile.sv | 97 +++++++++
 5 files changed

// File: rtl/scoreboard_regfile_pkg.sv
// Shared decode-stage types and constants for the scoreboarded register file.
package decode_pkg;
  localparam int SB_TAG_BITS  = 4;
  localparam int SB_NUM_REGS  = 32;
  localparam int SB_ADDR_BITS = $clog2(SB_NUM_REGS);
  localparam int SB_ZERO_REG  = 0;

  typedef logic [SB_TAG_BITS-1:0]  sb_tag_t;
  typedef logic [SB_ADDR_BITS-1:0] sb_addr_t;
endpackage

// File: rtl/scoreboard_regfile_if.sv
// Issue, writeback and read-port bundle for scoreboard_regfile.
// master drives requests (decode/issue side); slave is the register file.
interface scoreboard_regfile_if #(
  parameter int p_entry_bits = 32,
  parameter int p_num_regs   = 32,
  parameter int p_num_rports = 2,
  parameter int p_num_wports = 2,
  parameter int p_tag_bits   = 4
);
  localparam int addr_bits = $clog2(p_num_regs);

  logic [p_num_rports-1:0][addr_bits-1:0]    raddr;
  logic [p_num_rports-1:0][p_entry_bits-1:0] rdata;
  logic [p_num_rports-1:0]                   rpend;
  logic [p_num_rports-1:0][p_tag_bits-1:0]   rtag;
  logic                                      iss_en;
  logic [addr_bits-1:0]                      iss_waddr;
  logic [p_tag_bits-1:0]                     iss_tag;
  logic [p_num_wports-1:0]                   wb_en;
  logic [p_num_wports-1:0][addr_bits-1:0]    wb_addr;
  logic [p_num_wports-1:0][p_entry_bits-1:0] wb_data;
  logic [p_num_wports-1:0][p_tag_bits-1:0]   wb_tag;
  logic                                      all_clear;

  modport master (
    output raddr, iss_en, iss_waddr, iss_tag, wb_en, wb_addr, wb_data, wb_tag,
    input  rdata, rpend, rtag, all_clear
  );

  modport slave (
    input  raddr, iss_en, iss_waddr, iss_tag, wb_en, wb_addr, wb_data, wb_tag,
    output rdata, rpend, rtag, all_clear
  );

  modport monitor (
    input raddr, iss_en, iss_waddr, iss_tag, wb_en, wb_addr, wb_data, wb_tag,
    input rdata, rpend, rtag, all_clear
  );
endinterface

// File: rtl/scoreboard_regfile_chk.sv
// Protocol checker: two writeback ports must never target the same register
// with the same producer tag in one cycle (tags are unique per producer).
module scoreboard_regfile_chk
  import decode_pkg::*;
#(
  parameter int p_num_regs   = 32,
  parameter int p_num_wports = 2
) (
  input logic                   clk,
  input logic                   rst,
  scoreboard_regfile_if.monitor sb
);
  localparam int addr_bits = $clog2(p_num_regs);

  // Pairwise duplicate-writeback check on every active edge out of reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < p_num_wports; i++) begin
        for (int j = i + 1; j < p_num_wports; j++) begin
          assert (!(sb.wb_en[i] && sb.wb_en[j] &&
                    (sb.wb_addr[i] == sb.wb_addr[j]) &&
                    (sb.wb_addr[i] != addr_bits'(SB_ZERO_REG)) &&
                    (sb.wb_tag[i] == sb.wb_tag[j])))
            else $error("duplicate writeback on ports %0d/%0d", i, j);
        end
      end
    end
  end

endmodule

// File: rtl/scoreboard_regfile_rport.sv
// One combinational read port: x0 forced to zero, array select, and (with
// SBRF_WB_BYPASS_EN defined) same-cycle forwarding of accepted writebacks.
module scoreboard_regfile_rport
  import decode_pkg::*;
#(
  parameter int p_entry_bits = 32,
  parameter int p_num_regs   = 32,
  parameter int p_num_wports = 2,
  parameter int p_tag_bits   = 4,
  localparam int addr_bits   = $clog2(p_num_regs)
) (
  input  logic [p_num_regs-1:0][p_entry_bits-1:0]   regs,
  input  logic [p_num_regs-1:0]                     pend,
  input  logic [p_num_regs-1:0][p_tag_bits-1:0]     tags,
  input  logic [addr_bits-1:0]                      raddr,
  input  logic [p_num_wports-1:0]                   wb_acc,
  input  logic [p_num_wports-1:0][addr_bits-1:0]    wb_addr,
  input  logic [p_num_wports-1:0][p_entry_bits-1:0] wb_data,
  input  logic                                      iss_ok,
  input  logic [addr_bits-1:0]                      iss_waddr,
  output logic [p_entry_bits-1:0]                   rdata,
  output logic                                      rpend,
  output logic [p_tag_bits-1:0]                     rtag
);

  // Read mux; later ports override earlier ones so the highest accepted wb wins.
  always_comb begin
    rdata = '0;
    rpend = 1'b0;
    rtag  = '0;
    if (raddr != addr_bits'(SB_ZERO_REG)) begin
      rdata = regs[raddr];
      rpend = pend[raddr];
      rtag  = tags[raddr];
`ifdef SBRF_WB_BYPASS_EN
      for (int w = 0; w < p_num_wports; w++) begin
        rdata = (wb_acc[w] && (wb_addr[w] == raddr)) ? wb_data[w] : rdata;
        // A same-cycle re-issue keeps the register pending.
        rpend = (wb_acc[w] && (wb_addr[w] == raddr) &&
                 !(iss_ok && (iss_waddr == raddr))) ? 1'b0 : rpend;
      end
`endif
    end else begin
      rdata = '0;
      rpend = 1'b0;
      rtag  = '0;
    end
  end

`ifndef SBRF_WB_BYPASS_EN
  logic unused_bypass_s;
  assign unused_bypass_s = ^{wb_acc, wb_addr, wb_data, iss_ok, iss_waddr};
`endif

endmodule

// File: rtl/scoreboard_regfile.sv
// Multi-ported register file with per-register producer-tag scoreboard.
// Optional same-cycle writeback bypass on reads: define SBRF_WB_BYPASS_EN.
module scoreboard_regfile
  import decode_pkg::*;
#(
  parameter int p_entry_bits = 32,
  parameter int p_num_regs   = 32,
  parameter int p_num_rports = 2,
  parameter int p_num_wports = 2,
  parameter int p_tag_bits   = 4
) (
  input logic                clk,
  input logic                rst,
  scoreboard_regfile_if.slave sb
);
  localparam int addr_bits = $clog2(p_num_regs);

  logic [p_num_regs-1:0][p_entry_bits-1:0] regs_r, regs_n_s;
  logic [p_num_regs-1:0]                   pend_r, pend_n_s;
  logic [p_num_regs-1:0][p_tag_bits-1:0]   tag_r, tag_n_s;
  logic [p_num_wports-1:0]                 wb_acc_s;
  logic                                    iss_ok_s;

  // Writeback acceptance: only the live producer of a pending register may write.
  always_comb begin
    wb_acc_s = '0;
    for (int w = 0; w < p_num_wports; w++) begin
      wb_acc_s[w] = sb.wb_en[w] &&
                    (sb.wb_addr[w] != addr_bits'(SB_ZERO_REG)) &&
                    pend_r[sb.wb_addr[w]] &&
                    (tag_r[sb.wb_addr[w]] == sb.wb_tag[w]);
    end
    iss_ok_s = sb.iss_en && (sb.iss_waddr != addr_bits'(SB_ZERO_REG));
  end

  // Next state: writebacks in port order, then issue overrides the scoreboard.
  always_comb begin
    regs_n_s = regs_r;
    pend_n_s = pend_r;
    tag_n_s  = tag_r;
    for (int w = 0; w < p_num_wports; w++) begin
      regs_n_s[sb.wb_addr[w]] = wb_acc_s[w] ? sb.wb_data[w] : regs_n_s[sb.wb_addr[w]];
      pend_n_s[sb.wb_addr[w]] = wb_acc_s[w] ? 1'b0 : pend_n_s[sb.wb_addr[w]];
    end
    pend_n_s[sb.iss_waddr] = iss_ok_s ? 1'b1 : pend_n_s[sb.iss_waddr];
    tag_n_s[sb.iss_waddr]  = iss_ok_s ? sb.iss_tag : tag_n_s[sb.iss_waddr];
    regs_n_s[SB_ZERO_REG]  = '0;
    pend_n_s[SB_ZERO_REG]  = 1'b0;
    tag_n_s[SB_ZERO_REG]   = '0;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_r <= '0;
      pend_r <= '0;
      tag_r  <= '0;
    end else begin
      regs_r <= regs_n_s;
      pend_r <= pend_n_s;
      tag_r  <= tag_n_s;
    end
  end

  assign sb.all_clear = ~|pend_r;

  for (genvar r = 0; r < p_num_rports; r++) begin : g_rport
    logic [p_entry_bits-1:0] rdata_s;
    logic                    rpend_s;
    logic [p_tag_bits-1:0]   rtag_s;

    scoreboard_regfile_rport #(
      .p_entry_bits (p_entry_bits),
      .p_num_regs   (p_num_regs),
      .p_num_wports (p_num_wports),
      .p_tag_bits   (p_tag_bits)
    ) u_rport (
      .regs      (regs_r),
      .pend      (pend_r),
      .tags      (tag_r),
      .raddr     (sb.raddr[r]),
      .wb_acc    (wb_acc_s),
      .wb_addr   (sb.wb_addr),
      .wb_data   (sb.wb_data),
      .iss_ok    (iss_ok_s),
      .iss_waddr (sb.iss_waddr),
      .rdata     (rdata_s),
      .rpend     (rpend_s),
      .rtag      (rtag_s)
    );

    assign sb.rdata[r] = rdata_s;
    assign sb.rpend[r] = rpend_s;
    assign sb.rtag[r]  = rtag_s;
  end

endmodule
